mag_cmp_seq16: RTL

MAG_CMP_SEQ16 -- requirements
Module: mag_cmp_seq16

---
 rtl/cmp_pkg.sv | 20 ++
 rtl/cmp_nibble.sv | 16 +
 rtl/mag_cmp_seq16.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the sequential nibble-serial magnitude comparator.
package cmp_pkg;

  localparam int unsigned NIB_W     = 4;
  localparam int unsigned N_NIB_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot-by-construction compare result: exactly one bit set after a run.
  typedef struct packed {
    logic e;
    logic g;
    logic l;
  } cmp_res_t;

endpackage

// File: rtl/cmp_nibble.sv
// Combinational 4-bit unsigned magnitude compare of one nibble pair.
module cmp_nibble
  import cmp_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  assign eq = (x == y);
  assign gt = (x > y);
  assign lt = (x < y);

endmodule

// File: rtl/mag_cmp_seq16.sv
// Sequential magnitude comparator: walks operand nibbles MSB-first through one
// shared nibble comparator and stops at the first differing nibble.
module mag_cmp_seq16
  import cmp_pkg::*;
#(
  parameter  int unsigned N_NIB  = N_NIB_DEF,
  localparam int unsigned OP_W   = NIB_W * N_NIB,
  localparam int unsigned IDX_W  = (N_NIB > 1) ? $clog2(N_NIB) : 1,
  localparam int unsigned NCMP_W = $clog2(N_NIB + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic              e,
  output logic              g,
  output logic              l,
  output logic [NCMP_W-1:0] ncmp
);

  state_t              state_q, state_d;
  logic [OP_W-1:0]     a_q, a_d;
  logic [OP_W-1:0]     b_q, b_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NCMP_W-1:0]   ncmp_q, ncmp_d;
  cmp_res_t            res_q, res_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [NIB_W-1:0]    nib_a, nib_b;
  logic                nib_eq, nib_gt, nib_lt;

  // Nibble mux feeding the single shared comparator.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned i = 0; i < N_NIB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a = a_q[i*NIB_W +: NIB_W];
        nib_b = b_q[i*NIB_W +: NIB_W];
      end
    end
  end

  cmp_nibble u_cmp_nibble (
    .x  (nib_a),
    .y  (nib_b),
    .eq (nib_eq),
    .gt (nib_gt),
    .lt (nib_lt)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    ncmp_d  = ncmp_q;
    res_d   = res_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_W'(N_NIB - 1);
          ncmp_d  = '0;
          res_d   = '0;
          state_d = CMP;
        end
      end
      CMP: begin
        ncmp_d = ncmp_q + NCMP_W'(1);
        if (!nib_eq) begin
          res_d.g = nib_gt;
          res_d.l = nib_lt;
          state_d = DONE;
        end else if (idx_q == '0) begin
          res_d.e = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      ncmp_q  <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      ncmp_q  <= ncmp_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign e    = res_q.e;
  assign g    = res_q.g;
  assign l    = res_q.l;
  assign ncmp = ncmp_q;

endmodule
